// File: rtl/mult_share_sched_if.sv
// Request, multiplier and response bundle for mult_share_sched.
// The slave side is the scheduler; the master side is requesters plus multiplier.
interface mult_share_sched_if #(
    parameter int WIDTH = 2,
    parameter int NREQ  = 4,
    parameter int ID_W  = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic [2*WIDTH-1:0]    mul_p;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [2*WIDTH-1:0]    rsp_p;
    logic                  busy;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output mul_p,
        output rsp_ready,
        input  req_ready,
        input  mul_a,
        input  mul_b,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_p,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  mul_p,
        input  rsp_ready,
        output req_ready,
        output mul_a,
        output mul_b,
        output rsp_valid,
        output rsp_id,
        output rsp_p,
        output busy
    );
endinterface

// File: rtl/mult_share_sched.sv
// Round-robin scheduler time-sharing one combinational multiplier.
// One op in flight: grant, hold operands SETTLE_CYC cycles, return product.
module mult_share_sched #(
    parameter int WIDTH      = 2,
    parameter int NREQ       = 4,
    parameter int ID_W       = 2,
    parameter int SETTLE_CYC = 1
) (
    input logic            clk,
    input logic            rst,
    mult_share_sched_if.slave bus
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      op_id;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     mul_a_q;
    logic [WIDTH-1:0]     mul_b_q;
    logic                 rsp_valid_q;
    logic [ID_W-1:0]      rsp_id_q;
    logic [2*WIDTH-1:0]   rsp_p_q;

    logic                 gnt_found;
    logic [ID_W-1:0]      gnt_idx;
    logic [NREQ-1:0]      req_ready_c;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;
    logic                 load_op;
    logic                 load_rsp;
    logic                 clr_rsp;
    logic                 cnt_dec;

    // Index base+off reduced modulo NREQ (off is always < NREQ).
    function automatic logic [ID_W-1:0] wrap_add(
        input logic [ID_W-1:0] base,
        input int              off
    );
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return ID_W'(sum);
    endfunction

    // Priority search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && bus.req_valid[wrap_add(rr_ptr, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_add(rr_ptr, k);
            end
        end
    end

    assign sel_a = bus.req_a[gnt_idx*WIDTH +: WIDTH];
    assign sel_b = bus.req_b[gnt_idx*WIDTH +: WIDTH];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes; grant is gated off while in reset.
    always_comb begin
        state_next  = state;
        req_ready_c = '0;
        load_op     = 1'b0;
        load_rsp    = 1'b0;
        clr_rsp     = 1'b0;
        cnt_dec     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rst && gnt_found) begin
                    req_ready_c[gnt_idx] = 1'b1;
                    load_op              = 1'b1;
                    state_next           = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    load_rsp   = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    clr_rsp    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch, priority pointer and settle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
            op_id   <= '0;
            rr_ptr  <= '0;
            cnt     <= '0;
        end else if (load_op) begin
            mul_a_q <= sel_a;
            mul_b_q <= sel_b;
            op_id   <= gnt_idx;
            rr_ptr  <= wrap_add(gnt_idx, 1);
            cnt     <= CNT_INIT;
        end else if (cnt_dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Response register: capture product, hold until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_p_q     <= '0;
        end else if (load_rsp) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= op_id;
            rsp_p_q     <= bus.mul_p;
        end else if (clr_rsp) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_p     = rsp_p_q;
    assign bus.busy      = (state != IDLE);

    // Grant is one-hot at most and only to a valid requester.
    a_gnt_onehot: assert property (
        @(posedge clk) disable iff (rst)
        $onehot0(req_ready_c)
    );

    a_gnt_valid: assert property (
        @(posedge clk) disable iff (rst)
        (req_ready_c & ~bus.req_valid) == '0
    );

    a_gnt_idle: assert property (
        @(posedge clk) disable iff (rst)
        (state != IDLE) |-> (req_ready_c == '0)
    );

    // Response payload stays put under backpressure.
    a_rsp_hold: assert property (
        @(posedge clk) disable iff (rst)
        (rsp_valid_q && !bus.rsp_ready)
            |=> (rsp_valid_q && $stable(rsp_p_q) && $stable(rsp_id_q))
    );

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched; the bench models the multiplier.
// A second instance exercises SETTLE_CYC=3.
module tb_mult_share_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   hs_cnt = 0;

    mult_share_sched_if #(.WIDTH(2), .NREQ(4), .ID_W(2)) bus ();
    mult_share_sched_if #(.WIDTH(2), .NREQ(4), .ID_W(2)) bus3 ();

    mult_share_sched #(
        .WIDTH(2), .NREQ(4), .ID_W(2), .SETTLE_CYC(1)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    mult_share_sched #(
        .WIDTH(2), .NREQ(4), .ID_W(2), .SETTLE_CYC(3)
    ) u_dut3 (
        .clk(clk),
        .rst(rst),
        .bus(bus3)
    );

    assign bus.mul_p  = 4'(bus.mul_a) * 4'(bus.mul_b);
    assign bus3.mul_p = 4'(bus3.mul_a) * 4'(bus3.mul_b);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rsp_valid && bus.rsp_ready) begin
            hs_cnt <= hs_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.rsp_ready  = 1'b1;
        bus3.req_valid = '0;
        bus3.req_a     = '0;
        bus3.req_b     = '0;
        bus3.rsp_ready = 1'b1;
    endtask

    task automatic drive(input int i, input logic [1:0] a, input logic [1:0] b);
        bus.req_valid[i]     = 1'b1;
        bus.req_a[i*2 +: 2]  = a;
        bus.req_b[i*2 +: 2]  = b;
    endtask

    task automatic drop(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic pulse_reset;
        clear_inputs();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_grant(output logic [3:0] g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                g  = bus.req_ready;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [16:0] outs;
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            bus.req_valid = 4'($urandom);
            bus.req_a     = 8'($urandom);
            bus.req_b     = 8'($urandom);
            bus.rsp_ready = 1'($urandom);
            @(negedge clk);
            outs = {bus.req_ready, bus.mul_a, bus.mul_b, bus.rsp_valid,
                    bus.rsp_id, bus.rsp_p, bus.busy};
            checks++;
            if (outs !== '0) begin
                failures++;
                $display("FAIL reset_outs got=%h expected=0", outs);
            end
        end
        clear_inputs();
        step();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            outs = {bus.req_ready, bus.mul_a, bus.mul_b, bus.rsp_valid,
                    bus.rsp_id, bus.rsp_p, bus.busy};
            checks++;
            if (outs !== '0) begin
                failures++;
                $display("FAIL post_reset_idle got=%h expected=0", outs);
            end
            checks++;
            if ({bus3.rsp_valid, bus3.busy, bus3.req_ready} !== '0) begin
                failures++;
                $display("FAIL post_reset_idle3 got=%b expected=0",
                         {bus3.rsp_valid, bus3.busy, bus3.req_ready});
            end
        end
    endtask

    task automatic test_single;
        logic [3:0] g;
        bit         ok;
        int         lat;
        step();
        drive(1, 2'd3, 2'd3);
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== 4'b0010) begin
            failures++;
            $display("FAIL single_grant got=%b expected=0010", g);
        end
        step();
        drop(1);
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.busy, bus.rsp_valid, bus.mul_a, bus.mul_b}
            !== {4'b0000, 1'b1, 1'b0, 2'd3, 2'd3}) begin
            failures++;
            $display("FAIL single_settle got=%b_%b_%b_%0d_%0d expected=0000_1_0_3_3",
                     bus.req_ready, bus.busy, bus.rsp_valid, bus.mul_a, bus.mul_b);
        end
        @(negedge clk);
        lat = 2;
        ok  = bus.rsp_valid;
        checks++;
        if (!ok || {bus.rsp_id, bus.rsp_p} !== {2'd1, 4'd9}) begin
            failures++;
            $display("FAIL single_rsp got=v%0b id%0d p%0d expected=v1 id1 p9 lat=%0d",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_p, lat);
        end
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.busy, bus.mul_a, bus.mul_b}
            !== {1'b0, 1'b0, 2'd3, 2'd3}) begin
            failures++;
            $display("FAIL single_done got=v%0b busy%0b a%0d b%0d expected=v0 busy0 a3 b3",
                     bus.rsp_valid, bus.busy, bus.mul_a, bus.mul_b);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] exp_p [5] = '{4'd3, 4'd2, 4'd6, 4'd2, 4'd9};
        logic [3:0] g;
        bit         ok;
        int         lat;
        pulse_reset();
        drive(0, 2'd1, 2'd3);
        drive(1, 2'd1, 2'd2);
        drive(2, 2'd3, 2'd2);
        drive(3, 2'd2, 2'd1);
        for (int i = 0; i < 5; i++) begin
            wait_grant(g, ok);
            checks++;
            if (!ok || g !== exp_g[i]) begin
                failures++;
                $display("FAIL rr_grant%0d got=%b expected=%b", i, g, exp_g[i]);
            end
            step();
            drop(i % 4);
            if (i == 3) begin
                drive(0, 2'd3, 2'd3);
            end
            wait_rsp(lat, ok);
            checks++;
            if (!ok || lat != 2 || bus.rsp_id !== 2'(i % 4) || bus.rsp_p !== exp_p[i]) begin
                failures++;
                $display("FAIL rr_rsp%0d got=id%0d p%0d lat%0d expected=id%0d p%0d lat2",
                         i, bus.rsp_id, bus.rsp_p, lat, i % 4, exp_p[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] g;
        bit         ok;
        int         lat;
        int         base;
        pulse_reset();
        bus.rsp_ready = 1'b0;
        drive(1, 2'd2, 2'd3);
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== 4'b0010) begin
            failures++;
            $display("FAIL bp_grant got=%b expected=0010", g);
        end
        step();
        drop(1);
        wait_rsp(lat, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_rsp got=no rsp_valid expected=rsp_valid");
        end
        drive(2, 2'd3, 2'd1);
        base = hs_cnt;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_p, bus.req_ready}
                !== {1'b1, 2'd1, 4'd6, 4'b0000}) begin
                failures++;
                $display("FAIL bp_hold%0d got=v%0b id%0d p%0d rdy%b expected=v1 id1 p6 rdy0000",
                         n, bus.rsp_valid, bus.rsp_id, bus.rsp_p, bus.req_ready);
            end
        end
        step();
        bus.rsp_ready = 1'b1;
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== 4'b0100 || hs_cnt - base != 1) begin
            failures++;
            $display("FAIL bp_release got=g%b hs%0d expected=g0100 hs1",
                     g, hs_cnt - base);
        end
        step();
        drop(2);
        wait_rsp(lat, ok);
        checks++;
        if (!ok || {bus.rsp_id, bus.rsp_p} !== {2'd2, 4'd3}) begin
            failures++;
            $display("FAIL bp_pending_rsp got=id%0d p%0d expected=id2 p3",
                     bus.rsp_id, bus.rsp_p);
        end
    endtask

    task automatic test_wrap_skip;
        logic [3:0] g;
        bit         ok;
        int         lat;
        pulse_reset();
        drive(2, 2'd1, 2'd2);
        wait_grant(g, ok);
        step();
        drop(2);
        wait_rsp(lat, ok);
        drive(0, 2'd3, 2'd2);
        drive(2, 2'd1, 2'd1);
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_grant0 got=%b expected=0001", g);
        end
        step();
        drop(0);
        wait_rsp(lat, ok);
        checks++;
        if (!ok || {bus.rsp_id, bus.rsp_p} !== {2'd0, 4'd6}) begin
            failures++;
            $display("FAIL wrap_rsp0 got=id%0d p%0d expected=id0 p6",
                     bus.rsp_id, bus.rsp_p);
        end
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== 4'b0100) begin
            failures++;
            $display("FAIL wrap_grant2 got=%b expected=0100", g);
        end
        step();
        drop(2);
        wait_rsp(lat, ok);
        checks++;
        if (!ok || {bus.rsp_id, bus.rsp_p} !== {2'd2, 4'd1}) begin
            failures++;
            $display("FAIL wrap_rsp2 got=id%0d p%0d expected=id2 p1",
                     bus.rsp_id, bus.rsp_p);
        end
    endtask

    task automatic test_settle3;
        bit ok;
        int lat;
        pulse_reset();
        bus3.req_valid[3]   = 1'b1;
        bus3.req_a[6 +: 2]  = 2'd3;
        bus3.req_b[6 +: 2]  = 2'd3;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus3.req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || bus3.req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL s3_grant got=%b expected=1000", bus3.req_ready);
        end
        step();
        bus3.req_valid = '0;
        ok  = 1'b0;
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            lat++;
            if (bus3.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || lat != 4 || {bus3.rsp_id, bus3.rsp_p} !== {2'd3, 4'd9}) begin
            failures++;
            $display("FAIL s3_rsp got=lat%0d id%0d p%0d expected=lat4 id3 p9",
                     lat, bus3.rsp_id, bus3.rsp_p);
        end
    endtask

    task automatic test_reset_midop;
        logic [3:0] g;
        bit         ok;
        int         lat;
        step();
        drive(1, 2'd2, 2'd2);
        wait_grant(g, ok);
        step();
        drop(1);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.busy, bus.mul_a} !== 4'b0) begin
            failures++;
            $display("FAIL midop_reset got=v%0b busy%0b a%0d expected=v0 busy0 a0",
                     bus.rsp_valid, bus.busy, bus.mul_a);
        end
        step();
        step();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
                failures++;
                $display("FAIL midop_norsp got=v%0b busy%0b expected=v0 busy0",
                         bus.rsp_valid, bus.busy);
            end
        end
        drive(3, 2'd2, 2'd3);
        wait_grant(g, ok);
        checks++;
        if (!ok || g !== 4'b1000) begin
            failures++;
            $display("FAIL midop_grant got=%b expected=1000", g);
        end
        step();
        drop(3);
        wait_rsp(lat, ok);
        checks++;
        if (!ok || lat != 2 || {bus.rsp_id, bus.rsp_p} !== {2'd3, 4'd6}) begin
            failures++;
            $display("FAIL midop_rsp got=id%0d p%0d lat%0d expected=id3 p6 lat2",
                     bus.rsp_id, bus.rsp_p, lat);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_settle3();
        test_reset_midop();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
